sram_like_slave: RTL and testbench

- SRAM-like responder: the slave end of the req/addr_ok/data_ok protocol driven by the fetch and memory stages.
- Accepts requests, issues them to a 1-cycle synchronous RAM, and returns in-order responses after a configurable delay.
- Address-acceptance stall and response latency are both tunable, so masters can be exercised against a slow memory.
- Sits between a pipeline-stage SRAM-like port and the backing RAM macro.

---
 rtl/sram_like_pkg.sv | 20 ++
 rtl/sram_resp_fifo.sv | 83 ++++++++
 rtl/sram_like_slave.sv | 86 ++++++++
 tb/tb_sram_like_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like slave and its response FIFO.
package sram_like_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int STRB_W    = 4;
    localparam int DEPTH_MAX = 4;
    localparam int CNT_W     = 4;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [CNT_W-1:0]  cnt;
    } resp_entry_t;

    // Countdown step that parks at zero.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response FIFO; every entry counts down its delay while queued and the
// head is released once its count reaches zero. An entry pushed into an empty
// FIFO is visible as head in its push cycle.
module sram_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  resp_entry_t       push_entry,
    output logic              head_ready,
    output logic [DATA_W-1:0] head_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    resp_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;

    resp_entry_t head;
    logic        empty;
    logic        head_valid;
    logic        pop;
    logic        store;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        head       = push_entry;
        head_ready = 1'b0;
        head_rdata = '0;
        pop        = 1'b0;
        store      = 1'b0;
        empty      = (count == '0);
        head_valid = !empty || push;
        if (!empty) begin
            head = mem[rd_ptr];
        end
        if (head_valid) begin
            head_ready = (head.cnt == '0);
            head_rdata = head.rdata;
        end
        pop   = head_ready && !empty;
        // A push into an empty FIFO that is already due leaves straight away.
        store = push && !(empty && head_ready);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + OCC_W'(store) - OCC_W'(pop);
        end
    end

    // NOTE: payload storage has no reset; validity is carried only by count and pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i].cnt <= cnt_dec(mem[i].cnt);
        end
        if (store) begin
            mem[wr_ptr] <= '{rdata: push_entry.rdata, cnt: cnt_dec(push_entry.cnt)};
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like slave: accepts req/addr_ok handshakes, drives a 1-cycle synchronous
// RAM and returns in-order data_ok responses after a programmable delay.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int RAM_AW        = 16,
    parameter int DEPTH         = 2,
    parameter int ADDR_OK_DELAY = 0,
    parameter int RESP_DELAY    = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic [STRB_W-1:0] ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int OCC_W = $clog2(DEPTH_MAX + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [OCC_W-1:0] outstanding;
    logic             cap_v;
    logic             cap_wr;
    logic             wait_done;
    logic             handshake;
    resp_entry_t      push_entry;

    // Byte lanes come from wstrb and the word address drops addr[1:0].
    logic unused_inputs;
    assign unused_inputs = ^{size, addr};

    always_comb begin
        wait_done  = (wait_cnt == CNT_W'(ADDR_OK_DELAY));
        // Registered occupancy only: a pop this cycle cannot free a slot for this cycle.
        addr_ok    = req && (outstanding < OCC_W'(DEPTH)) && wait_done;
        handshake  = req && addr_ok;

        ram_en     = handshake;
        ram_we     = (handshake && wr) ? wstrb : '0;
        ram_addr   = addr[RAM_AW+1:2];
        ram_wdata  = wdata;

        push_entry = '{rdata: (cap_wr ? '0 : ram_rdata), cnt: CNT_W'(RESP_DELAY)};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt    <= '0;
            outstanding <= '0;
            cap_v       <= 1'b0;
            cap_wr      <= 1'b0;
        end else begin
            if (!req || handshake) begin
                wait_cnt <= '0;
            end else if (!wait_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            cap_v       <= handshake;
            cap_wr      <= handshake && wr;
            outstanding <= outstanding + OCC_W'(handshake) - OCC_W'(data_ok);
        end
    end

    sram_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (cap_v),
        .push_entry (push_entry),
        .head_ready (data_ok),
        .head_rdata (rdata)
    );

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three parameterisations, directed tables/sequences
// plus random traffic checked against a transaction-level reference model.
module tb_sram_like_slave;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        resetn    [3];
    logic        req       [3];
    logic        wr        [3];
    logic [1:0]  size      [3];
    logic [3:0]  wstrb     [3];
    logic [31:0] addr      [3];
    logic [31:0] wdata     [3];
    logic        addr_ok   [3];
    logic        data_ok   [3];
    logic [31:0] rdata     [3];
    logic        ram_en    [3];
    logic [3:0]  ram_we    [3];
    logic [15:0] ram_addr  [3];
    logic [31:0] ram_wdata [3];
    logic [31:0] ram_rdata [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] init_word(input int k, input int i);
        return 32'h5a00_0000 | (32'(k) << 16) | 32'(i);
    endfunction

    typedef struct {
        int          due;
        logic [31:0] rdata;
    } exp_t;

    // Instance 0: defaults. 1: DEPTH=2, RESP_DELAY=3. 2: DEPTH=4, ADDR_OK_DELAY=2, RESP_DELAY=1.
    for (genvar k = 0; k < 3; k++) begin : g_model
        localparam int D   = (k == 2) ? 4 : 2;
        localparam int AOD = (k == 2) ? 2 : 0;
        localparam int RD  = (k == 1) ? 3 : ((k == 2) ? 1 : 0);

        logic [31:0] ram_mem [256];
        logic [31:0] shadow  [256];
        logic [31:0] rd_q;
        exp_t        q [$];
        int          wcnt = 0;
        int          last_due = -10;
        int          pops = 0;
        int          seen = 0;
        bit          armed = 1'b0;

        sram_like_slave #(
            .RAM_AW        (16),
            .DEPTH         (D),
            .ADDR_OK_DELAY (AOD),
            .RESP_DELAY    (RD)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn[k]),
            .req       (req[k]),
            .wr        (wr[k]),
            .size      (size[k]),
            .wstrb     (wstrb[k]),
            .addr      (addr[k]),
            .wdata     (wdata[k]),
            .addr_ok   (addr_ok[k]),
            .data_ok   (data_ok[k]),
            .rdata     (rdata[k]),
            .ram_en    (ram_en[k]),
            .ram_we    (ram_we[k]),
            .ram_addr  (ram_addr[k]),
            .ram_wdata (ram_wdata[k]),
            .ram_rdata (ram_rdata[k])
        );

        initial begin
            rd_q = '0;
            for (int i = 0; i < 256; i++) begin
                ram_mem[i] = init_word(k, i);
                shadow[i]  = init_word(k, i);
            end
        end

        // Backing RAM: one-cycle synchronous read, byte-masked write, read-before-write.
        always @(posedge clk) begin
            if (ram_en[k]) begin
                rd_q <= ram_mem[ram_addr[k][7:0]];
                for (int b = 0; b < 4; b++)
                    if (ram_we[k][b]) ram_mem[ram_addr[k][7:0]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
            end
        end
        assign ram_rdata[k] = rd_q;

        // Reference model: occupancy is the queue length; each response is due at
        // accept+1+RD but never earlier than one cycle after the previous response.
        always @(negedge clk) begin
            logic        e_aok;
            logic        e_dok;
            logic [31:0] e_rd;
            logic [3:0]  e_we;
            int          w;
            int          due;
            e_aok = req[k] && (q.size() < D) && (wcnt == AOD);
            e_dok = (q.size() > 0) && (q[0].due == cyc);
            e_we  = (e_aok && wr[k]) ? wstrb[k] : 4'h0;
            if (armed) begin
                check($sformatf("m%0d addr_ok", k), 64'(addr_ok[k]), 64'(e_aok));
                check($sformatf("m%0d data_ok", k), 64'(data_ok[k]), 64'(e_dok));
                check($sformatf("m%0d ram_en", k), 64'(ram_en[k]), 64'(e_aok));
                check($sformatf("m%0d ram_we", k), 64'(ram_we[k]), 64'(e_we));
                if (e_dok) check($sformatf("m%0d rdata", k), 64'(rdata[k]), 64'(q[0].rdata));
                if (q.size() == 0) check($sformatf("m%0d idle rdata", k), 64'(rdata[k]), 64'h0);
                if (e_aok) begin
                    check($sformatf("m%0d ram_addr", k), 64'(ram_addr[k]), 64'(addr[k][17:2]));
                    check($sformatf("m%0d ram_wdata", k), 64'(ram_wdata[k]), 64'(wdata[k]));
                end
                if (data_ok[k]) seen++;
            end
            if (e_dok) begin
                pops++;
                void'(q.pop_front());
            end
            if (e_aok) begin
                w = int'(addr[k][9:2]);
                if (wr[k]) begin
                    e_rd = 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[k][b]) shadow[w][8*b +: 8] = wdata[k][8*b +: 8];
                end else begin
                    e_rd = shadow[w];
                end
                due = (cyc + 1 + RD > last_due + 1) ? cyc + 1 + RD : last_due + 1;
                q.push_back('{due: due, rdata: e_rd});
                last_due = due;
            end
            if (!req[k] || e_aok) wcnt = 0;
            else if (wcnt != AOD) wcnt++;
            if (!resetn[k]) begin
                q.delete();
                wcnt     = 0;
                last_due = cyc;
                armed    = 1'b1;
            end
        end
    end

    typedef struct {
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_we;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int          acc_t [4];
        int          dok_t [4];
        logic [31:0] dok_d [4];
        int          na;
        int          nd;
        int          t0;
        int          n;
        int          lat;
        logic [31:0] got;
        logic [7:0]  req_pat;
        logic [7:0]  aok_got;

        for (int k = 0; k < 3; k++) begin
            resetn[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd2;
            wstrb[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        repeat (3) step();
        for (int k = 0; k < 3; k++) resetn[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset addr_ok %0d", k), 64'(addr_ok[k]), 64'h0);
            check($sformatf("reset data_ok %0d", k), 64'(data_ok[k]), 64'h0);
            check($sformatf("reset rdata %0d", k), 64'(rdata[k]), 64'h0);
        end

        // Defaults: write/read back-to-back, byte-lane merge, accept+pop at DEPTH-1.
        tbl[0] = '{1'b1, 1'b1, 4'hf, 32'h1c00_0000, 32'hdead_beef, 1'b1, 1'b0, 32'h0, 4'hf};
        tbl[1] = '{1'b1, 1'b0, 4'h0, 32'h1c00_0000, 32'h0,         1'b1, 1'b1, 32'h0, 4'h0};
        tbl[2] = '{1'b1, 1'b1, 4'hf, 32'h1c00_0004, 32'h1122_3344, 1'b1, 1'b1, 32'hdead_beef, 4'hf};
        tbl[3] = '{1'b1, 1'b1, 4'h2, 32'h1c00_0004, 32'h0000_ab00, 1'b1, 1'b1, 32'h0, 4'h2};
        tbl[4] = '{1'b1, 1'b0, 4'h0, 32'h1c00_0004, 32'h0,         1'b1, 1'b1, 32'h0, 4'h0};
        tbl[5] = '{1'b1, 1'b0, 4'h0, 32'h1c00_0000, 32'h0,         1'b1, 1'b1, 32'h1122_ab44, 4'h0};
        tbl[6] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hdead_beef, 4'h0};
        tbl[7] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0, 4'h0};
        for (int i = 0; i < 8; i++) begin
            step();
            req[0] = tbl[i].req; wr[0] = tbl[i].wr; wstrb[0] = tbl[i].wstrb;
            addr[0] = tbl[i].addr; wdata[0] = tbl[i].wdata;
            @(negedge clk);
            check($sformatf("tbl%0d addr_ok", i), 64'(addr_ok[0]), 64'(tbl[i].exp_aok));
            check($sformatf("tbl%0d data_ok", i), 64'(data_ok[0]), 64'(tbl[i].exp_dok));
            check($sformatf("tbl%0d rdata", i), 64'(rdata[0]), 64'(tbl[i].exp_rdata));
            check($sformatf("tbl%0d ram_we", i), 64'(ram_we[0]), 64'(tbl[i].exp_we));
        end

        // ADDR_OK_DELAY=2: accept at 2, then a req drop restarts the wait.
        req_pat = 8'b1110_1111;
        aok_got = 8'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            req[2] = req_pat[i]; wr[2] = 1'b0; addr[2] = 32'h20;
            @(negedge clk);
            aok_got[i] = addr_ok[2];
        end
        step();
        req[2] = 1'b0;
        check("wait addr_ok pattern", 64'(aok_got), 64'(8'b1000_0100));

        // DEPTH=2, RESP_DELAY=3: four reads with req held high.
        for (int i = 0; i < 4; i++) begin acc_t[i] = -1; dok_t[i] = -1; dok_d[i] = 32'h0; end
        na = 0; nd = 0;
        step();
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0;
        t0 = cyc;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (addr_ok[1] && na < 4) begin acc_t[na] = cyc - t0; na++; end
            if (data_ok[1] && nd < 4) begin dok_t[nd] = cyc - t0; dok_d[nd] = rdata[1]; nd++; end
            step();
            if (na < 4) addr[1] = 32'(na * 4);
            else req[1] = 1'b0;
        end
        check("slow acc0", 64'(acc_t[0]), 64'(0));
        check("slow acc1", 64'(acc_t[1]), 64'(1));
        check("slow acc2", 64'(acc_t[2]), 64'(5));
        check("slow acc3", 64'(acc_t[3]), 64'(6));
        check("slow dok0", 64'(dok_t[0]), 64'(4));
        check("slow dok1", 64'(dok_t[1]), 64'(5));
        check("slow dok2", 64'(dok_t[2]), 64'(9));
        check("slow dok3", 64'(dok_t[3]), 64'(10));
        for (int i = 0; i < 4; i++)
            check($sformatf("slow data%0d", i), 64'(dok_d[i]), 64'(init_word(1, i)));

        // Reset with two reads outstanding: no response, then normal service.
        req[1] = 1'b1; addr[1] = 32'h10;
        @(negedge clk);
        step();
        addr[1] = 32'h14;
        @(negedge clk);
        step();
        req[1] = 1'b0; resetn[1] = 1'b0;
        @(negedge clk);
        step();
        resetn[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (data_ok[1]) n++;
            step();
        end
        check("reset drops data_ok", 64'(n), 64'(0));
        req[1] = 1'b1; addr[1] = 32'h18;
        @(negedge clk);
        check("post-reset addr_ok", 64'(addr_ok[1]), 64'h1);
        t0 = cyc;
        step();
        req[1] = 1'b0;
        lat = -1; got = 32'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (data_ok[1] && lat < 0) begin lat = cyc - t0; got = rdata[1]; end
        end
        check("post-reset latency", 64'(lat), 64'(4));
        check("post-reset rdata", 64'(got), 64'(init_word(1, 6)));

        // Random traffic on all three instances, checked by the models.
        for (int c = 0; c < 400; c++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                req[k]   = ($urandom_range(0, 9) < 7);
                wr[k]    = 1'($urandom_range(0, 1));
                size[k]  = 2'($urandom_range(0, 3));
                wstrb[k] = 4'($urandom_range(0, 15));
                addr[k]  = 32'($urandom_range(0, 1023));
                wdata[k] = $urandom;
            end
        end
        step();
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        repeat (40) step();
        check("resp count 0", 64'(g_model[0].seen), 64'(g_model[0].pops));
        check("resp count 1", 64'(g_model[1].seen), 64'(g_model[1].pops));
        check("resp count 2", 64'(g_model[2].seen), 64'(g_model[2].pops));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
